// File: rtl/rd_writeback_scoreboard.sv
// rd_writeback_scoreboard: tracks pending register writes and decodes writeback into a one-hot write-enable
module rd_writeback_scoreboard #(
    parameter int ADDR_W = 5,
    parameter int NREGS  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_rd,
    output logic              issue_ready,
    input  logic [ADDR_W-1:0] rs1,
    input  logic [ADDR_W-1:0] rs2,
    output logic              rs1_busy,
    output logic              rs2_busy,
    output logic              stall,
    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_rd,
    output logic [NREGS-1:0]  wb_we_onehot,
    output logic [NREGS-1:0]  busy_vec,
    output logic [ADDR_W:0]   pending_count,
    output logic              wb_err
);
    logic             set_en, clr_en, set_new, clr_real;
    logic [NREGS-1:0] busy_nxt;

    assign issue_ready = (issue_rd == '0) | ~busy_vec[issue_rd] | (wb_valid & (wb_rd == issue_rd));
    assign set_en      = issue_valid & issue_ready & (issue_rd != '0);
    assign clr_en      = wb_valid & (wb_rd != '0);
    assign set_new     = set_en & ~busy_vec[issue_rd];
    assign clr_real    = clr_en & busy_vec[wb_rd] & ~(set_en & (issue_rd == wb_rd));
    assign rs1_busy    = (rs1 != '0) & busy_vec[rs1] & ~(wb_valid & (wb_rd == rs1));
    assign rs2_busy    = (rs2 != '0) & busy_vec[rs2] & ~(wb_valid & (wb_rd == rs2));
    assign stall       = rs1_busy | rs2_busy | (issue_valid & ~issue_ready);

    // next scoreboard: clear at writeback, then a same-register issue overrides it; x0 never tracked
    always_comb begin
        busy_nxt = busy_vec;
        if (clr_en) busy_nxt[wb_rd] = 1'b0;
        if (set_en) busy_nxt[issue_rd] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    // state update: scoreboard, count, registered write-enable decode and sticky error
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_vec      <= '0;
            pending_count <= '0;
            wb_we_onehot  <= '0;
            wb_err        <= 1'b0;
        end else begin
            busy_vec      <= busy_nxt;
            pending_count <= pending_count + (ADDR_W+1)'(set_new) - (ADDR_W+1)'(clr_real);
            wb_we_onehot  <= clr_en ? (NREGS'(1) << wb_rd) : '0;
            wb_err        <= wb_err | (clr_en & ~busy_vec[wb_rd]);
        end
    end
endmodule

// File: tb/tb_rd_writeback_scoreboard.sv
// tb_rd_writeback_scoreboard: directed stimulus with queued expectations checked by a monitor
module tb_rd_writeback_scoreboard;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        issue_valid = 1'b0;
    logic [4:0]  issue_rd = '0;
    logic        issue_ready;
    logic [4:0]  rs1 = '0;
    logic [4:0]  rs2 = '0;
    logic        rs1_busy, rs2_busy, stall;
    logic        wb_valid = 1'b0;
    logic [4:0]  wb_rd = '0;
    logic [31:0] wb_we_onehot, busy_vec;
    logic [5:0]  pending_count;
    logic        wb_err;

    typedef struct {
        int          sel;
        logic [31:0] val;
        string       name;
    } chk_t;

    chk_t        q[$];
    logic [31:0] wbq[$];
    int          checks = 0;
    int          failures = 0;
    chk_t        c;
    logic [31:0] w;

    rd_writeback_scoreboard dut (
        .clk(clk), .reset(reset),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
        .rs1(rs1), .rs2(rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .stall(stall),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_we_onehot(wb_we_onehot),
        .busy_vec(busy_vec), .pending_count(pending_count), .wb_err(wb_err)
    );

    always #5 clk = ~clk;

    localparam int BUSY = 0, CNT = 1, ONEHOT = 2, ERR = 3, READY = 4, RS1B = 5, RS2B = 6, STALL = 7;

    function automatic logic [31:0] act(input int sel);
        case (sel)
            BUSY:    return busy_vec;
            CNT:     return {26'd0, pending_count};
            ONEHOT:  return wb_we_onehot;
            ERR:     return {31'd0, wb_err};
            READY:   return {31'd0, issue_ready};
            RS1B:    return {31'd0, rs1_busy};
            RS2B:    return {31'd0, rs2_busy};
            default: return {31'd0, stall};
        endcase
    endfunction

    task automatic chk(input int sel, input logic [31:0] v, input string n);
        q.push_back('{sel: sel, val: v, name: n});
    endtask

    task automatic cyc(input logic iv, input logic [4:0] ird, input logic [4:0] r1, input logic [4:0] r2,
                       input logic wv, input logic [4:0] wrd);
        @(posedge clk);
        #1;
        issue_valid = iv;
        issue_rd    = ird;
        rs1         = r1;
        rs2         = r2;
        wb_valid    = wv;
        wb_rd       = wrd;
        if (wv && wrd != 5'd0) wbq.push_back(32'd1 << wrd);
    endtask

    // monitor: drain queued expectations and match every presented write-enable against the writeback queue
    always @(negedge clk) begin
        while (q.size() > 0) begin
            c = q.pop_front();
            checks++;
            if (act(c.sel) !== c.val) begin
                failures++;
                $display("FAIL %s: got %h expected %h at %0t", c.name, act(c.sel), c.val, $time);
            end
        end
        if (wb_we_onehot !== 32'd0) begin
            checks++;
            if (wbq.size() == 0) begin
                failures++;
                $display("FAIL wb_onehot_unexpected: got %h expected none at %0t", wb_we_onehot, $time);
            end else begin
                w = wbq.pop_front();
                if (wb_we_onehot !== w) begin
                    failures++;
                    $display("FAIL wb_onehot: got %h expected %h at %0t", wb_we_onehot, w, $time);
                end
            end
        end
    end

    initial begin
        @(posedge clk);
        #1;
        chk(BUSY, 0, "rst_busy"); chk(CNT, 0, "rst_count"); chk(ONEHOT, 0, "rst_onehot");
        chk(ERR, 0, "rst_err"); chk(READY, 1, "rst_ready"); chk(STALL, 0, "rst_stall");
        chk(RS1B, 0, "rst_rs1b"); chk(RS2B, 0, "rst_rs2b");
        @(posedge clk);
        #1 reset = 1'b0;
        cyc(1, 5, 0, 0, 0, 0);  chk(READY, 1, "iss5_ready"); chk(STALL, 0, "iss5_stall");
        cyc(0, 0, 5, 5, 0, 0);  chk(RS1B, 1, "raw_rs1b"); chk(RS2B, 1, "raw_rs2b"); chk(STALL, 1, "raw_stall");
                                chk(BUSY, 32'h20, "raw_busy"); chk(CNT, 1, "raw_count");
        cyc(0, 0, 5, 0, 0, 0);  chk(RS1B, 1, "raw_hold_rs1b");
        cyc(0, 0, 5, 5, 1, 5);  chk(RS1B, 0, "wb5_bypass_rs1b"); chk(RS2B, 0, "wb5_bypass_rs2b");
                                chk(STALL, 0, "wb5_bypass_stall");
        cyc(0, 0, 0, 0, 0, 0);  chk(BUSY, 0, "wb5_busy"); chk(CNT, 0, "wb5_count"); chk(ONEHOT, 32'h20, "wb5_onehot");
        cyc(0, 0, 0, 0, 0, 0);  chk(ONEHOT, 0, "wb5_onehot_clear");
        cyc(1, 7, 0, 0, 0, 0);  chk(READY, 1, "iss7_ready");
        cyc(1, 7, 0, 0, 0, 0);  chk(READY, 0, "waw_ready"); chk(STALL, 1, "waw_stall");
                                chk(BUSY, 32'h80, "waw_busy"); chk(CNT, 1, "waw_count");
        cyc(1, 7, 0, 0, 1, 7);  chk(READY, 1, "waw_bypass_ready"); chk(STALL, 0, "waw_bypass_stall");
        cyc(0, 0, 0, 0, 0, 0);  chk(BUSY, 32'h80, "setwin_busy"); chk(CNT, 1, "setwin_count"); chk(ERR, 0, "setwin_err");
        cyc(0, 0, 0, 0, 1, 7);
        cyc(0, 0, 0, 0, 0, 0);  chk(BUSY, 0, "wb7_busy"); chk(CNT, 0, "wb7_count"); chk(ERR, 0, "wb7_err");
        cyc(1, 0, 0, 0, 1, 0);  chk(READY, 1, "x0_ready"); chk(RS1B, 0, "x0_rs1b"); chk(STALL, 0, "x0_stall");
        cyc(0, 0, 0, 0, 0, 0);  chk(BUSY, 0, "x0_busy"); chk(CNT, 0, "x0_count"); chk(ONEHOT, 0, "x0_onehot");
                                chk(ERR, 0, "x0_err");
        cyc(0, 0, 0, 0, 1, 9);  chk(ERR, 0, "spur_err_pre");
        cyc(0, 0, 0, 0, 0, 0);  chk(ERR, 1, "spur_err"); chk(BUSY, 0, "spur_busy"); chk(CNT, 0, "spur_count");
        cyc(1, 3, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 3);  chk(BUSY, 32'h8, "iss3_busy"); chk(CNT, 1, "iss3_count");
        cyc(0, 0, 0, 0, 0, 0);  chk(ERR, 1, "sticky_err"); chk(BUSY, 0, "wb3_busy"); chk(CNT, 0, "wb3_count");
        @(posedge clk);
        #1 reset = 1'b1;
        chk(ERR, 0, "rst2_err"); chk(ONEHOT, 0, "rst2_onehot"); chk(BUSY, 0, "rst2_busy");
        @(posedge clk);
        #1 reset = 1'b0;
        cyc(0, 0, 0, 0, 1, 2);
        for (int i = 1; i < 32; i++) begin
            cyc(1, 5'(i), 0, 0, 0, 0);
            chk(READY, 1, "fill_ready");
        end
        cyc(0, 0, 31, 0, 0, 0); chk(CNT, 31, "fill_count"); chk(BUSY, 32'hFFFF_FFFE, "fill_busy");
                                chk(RS1B, 1, "fill_rs1b"); chk(STALL, 1, "fill_stall"); chk(ERR, 1, "fill_err");
        @(posedge clk);
        #2 reset = 1'b1;
        chk(BUSY, 0, "async_busy"); chk(CNT, 0, "async_count"); chk(ERR, 0, "async_err");
        chk(ONEHOT, 0, "async_onehot"); chk(RS1B, 0, "async_rs1b"); chk(STALL, 0, "async_stall");
        @(posedge clk);
        #1 reset = 1'b0;
        cyc(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        checks++;
        if (wbq.size() != 0) begin
            failures++;
            $display("FAIL wbq_drain: got %0d pending expected 0", wbq.size());
        end
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL chkq_drain: got %0d pending expected 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/rd_writeback_scoreboard.md
# rd_writeback_scoreboard

Destination-register decoder and pending-write scoreboard for the RISC-V core. It tracks which of the 32 architectural registers have an in-flight write. It sets a register's busy bit when an instruction issues with that destination, and clears it at writeback. At writeback it expands the 5-bit destination address into a registered one-hot register-file write-enable. It sits between decode/issue and the register file, and supplies the RAW/WAW stall signals for issue.

## Interface
Parameters:
- ADDR_W, 5, register address width
- NREGS, 32, number of architectural registers (2**ADDR_W)

Ports:
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- issue_valid  in  1  decode presents an instruction writing issue_rd
- issue_rd  in  ADDR_W  destination register of the issuing instruction
- issue_ready  out  1  issue accepted this cycle when issue_valid && issue_ready
- rs1, rs2  in  ADDR_W  source registers of the instruction in decode
- rs1_busy, rs2_busy  out  1  source has a pending write that is not being written back this cycle
- stall  out  1  rs1_busy | rs2_busy | (issue_valid & ~issue_ready)
- wb_valid  in  1  writeback of wb_rd this cycle
- wb_rd  in  ADDR_W  writeback destination register
- wb_we_onehot  out  NREGS  registered one-hot write-enable, one cycle after wb_valid
- busy_vec  out  NREGS  current scoreboard, bit i = register i pending
- pending_count  out  ADDR_W+1  number of set bits in busy_vec
- wb_err  out  1  sticky: writeback seen to a register that was not busy

## Operation
- State: busy_vec[NREGS-1:0], wb_we_onehot register, pending_count register, wb_err flag.
- Register x0 is never tracked:
  - busy_vec[0] is constantly 0.
  - Issue or writeback to x0 does not modify state.
  - wb to x0 produces wb_we_onehot = 0 and does not raise wb_err.
- An issue is accepted (issue_fire) when issue_valid && issue_ready. On issue_fire with issue_rd != 0, busy_vec[issue_rd] is set at the next edge.
- issue_ready = (issue_rd == 0) | ~busy_vec[issue_rd] | (wb_valid & wb_rd == issue_rd). This is combinational; WAW is resolved by writeback bypass.
- Writeback with wb_valid and wb_rd != 0:
  - Clears busy_vec[wb_rd] at the next edge.
  - If busy_vec[wb_rd] was 0, wb_err is set and stays set until reset. The clear is a no-op in that case.
- Same register set and cleared in the same cycle: the set wins, and the bit remains 1 (the new instruction owns it).
- rsN_busy = (rsN != 0) & busy_vec[rsN] & ~(wb_valid & wb_rd == rsN). This is combinational; a same-cycle writeback bypasses the stall.
- wb_we_onehot:
  - Next value is (wb_valid & wb_rd != 0) ? (1 << wb_rd) : 0.
  - At most one bit is ever set.
- pending_count tracks busy_vec exactly:
  - +1 on an accepted set of a clear bit.
  - -1 on a clear of a set bit.
  - Unchanged when set and clear hit the same register, or when both are no-ops.
  - Maximum value NREGS-1 (31). No overflow is possible.

## Timing
- Reset values: busy_vec = 0, wb_we_onehot = 0, pending_count = 0, wb_err = 0.
- With reset asserted and busy_vec = 0, the combinational outputs settle to issue_ready = 1, rs1_busy = rs2_busy = 0, and stall = 0 when issue_valid is low.
- Latency:
  - Issue to busy visible on rsN_busy: 1 cycle (next edge).
  - wb_valid to wb_we_onehot: 1 cycle.
  - wb_valid to stall release: 0 cycles, via bypass.
- issue_ready, rsN_busy and stall are purely combinational from the current state and inputs. They have no path through clk within the same cycle other than state.
- Reset asserted mid-operation clears all pending bits and wb_err asynchronously. Inputs are ignored while reset is high. Operation resumes on the first edge after deassertion.

## Test plan
- Reset, then idle:
  - busy_vec = 0, pending_count = 0, wb_we_onehot = 0, issue_ready = 1, stall = 0.
- Issue rd=5 at cycle 0, then rs1=5 at cycle 1:
  - rs1_busy = 1, stall = 1, busy_vec = 0x20, pending_count = 1.
  - wb_rd=5 at cycle 3: same cycle rs1_busy = 0. Next cycle wb_we_onehot = 0x20, busy_vec = 0, pending_count = 0.
- WAW on rd=7:
  - Second issue of rd=7 while busy gives issue_ready = 0 and stall = 1.
  - The same issue with a simultaneous wb_rd=7 gives issue_ready = 1. Afterwards busy_vec[7] = 1 and pending_count is unchanged (1).
- x0 handling:
  - Issue rd=0 and rs1=0 give busy_vec = 0 and rs1_busy = 0.
  - wb_rd=0 gives wb_we_onehot = 0 and wb_err = 0.
- Spurious writeback:
  - wb_rd=9 with busy_vec[9] = 0 sets wb_err = 1, which stays 1 after further valid traffic.
  - A subsequent reset returns wb_err to 0.
- Fill and reset mid-operation:
  - Issue rd=1..31 back-to-back, giving pending_count = 31 and busy_vec = 0xFFFFFFFE.
  - Assert reset between edges: all outputs return to reset values immediately, without waiting for a clock edge.
